// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decrypt stage. Walks the shuffled S RAM,
// swaps entries in place, XORs each keystream byte with the encrypted
// message and writes the plaintext out. The pass aborts on the first byte
// that is not a lowercase letter or a space, so the controller can try the
// next key.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_DMB,
    output logic              finish_DMB,
    output logic              key_wrong,
    output logic              busy,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    input  logic [7:0]        s_rddata,
    output logic [MSG_AW-1:0] enc_addr,
    input  logic [7:0]        enc_rddata,
    output logic [MSG_AW-1:0] dec_addr,
    output logic [7:0]        dec_wrdata,
    output logic              dec_wren
);

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        RD_SI,
        WAIT_SI,
        RD_SJ,
        WAIT_SJ,
        WR_I,
        WR_J,
        RD_F,
        WAIT_F,
        CHECK,
        DONE,
        FAIL
    } state_e;

    localparam logic [MSG_AW-1:0] LAST_K = MSG_AW'(MSG_LEN - 1);

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        e_q, e_d;

    logic [7:0]        plainByte;
    logic              plainValid;

    // Plaintext byte and its acceptance test: lowercase a..z or space.
    always_comb begin
        plainByte  = f_q ^ e_q;
        plainValid = ((plainByte >= 8'h61) && (plainByte <= 8'h7A)) ||
                     (plainByte == 8'h20);
    end

    // Next-state and datapath register updates for the 10-cycle byte loop.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        e_d     = e_q;
        case (state_q)
            IDLE: begin
                if (start_DMB) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = INC_I;
                end
            end
            INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = RD_SI;
            end
            RD_SI:   state_d = WAIT_SI;
            WAIT_SI: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                state_d = RD_SJ;
            end
            RD_SJ:   state_d = WAIT_SJ;
            WAIT_SJ: begin
                sj_d    = s_rddata;
                state_d = WR_I;
            end
            WR_I:    state_d = WR_J;
            WR_J:    state_d = RD_F;
            RD_F:    state_d = WAIT_F;
            WAIT_F: begin
                f_d     = s_rddata;
                e_d     = enc_rddata;
                state_d = CHECK;
            end
            CHECK: begin
                if (!plainValid) begin
                    state_d = FAIL;
                end else if (k_q == LAST_K) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = INC_I;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any pass in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= '0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            f_q     <= 8'd0;
            e_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            e_q     <= e_d;
        end
    end

    // Moore output decode; buses read zero in states that do not use them.
    always_comb begin
        finish_DMB = 1'b0;
        key_wrong  = 1'b0;
        busy       = (state_q != IDLE);
        s_addr     = 8'd0;
        s_wrdata   = 8'd0;
        s_wren     = 1'b0;
        enc_addr   = '0;
        dec_addr   = '0;
        dec_wrdata = 8'd0;
        dec_wren   = 1'b0;
        case (state_q)
            RD_SI: s_addr = i_q;
            RD_SJ: s_addr = j_q;
            WR_I: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
            end
            WR_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
            end
            RD_F: begin
                s_addr   = si_q + sj_q;
                enc_addr = k_q;
            end
            CHECK: begin
                if (plainValid) begin
                    dec_addr   = k_q;
                    dec_wrdata = plainByte;
                    dec_wren   = 1'b1;
                end
            end
            DONE:    finish_DMB = 1'b1;
            FAIL:    key_wrong  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Self-checking bench for rc4_prga_decrypt: a 4-byte instance for the
// directed cases and a 32-byte instance checked against a software RC4 model.
module tb_rc4_prga_decrypt;

    logic clk = 1'b0;
    logic rst_n;
    logic startDrv;
    logic sel;

    logic       start4, fin4, kw4, busy4, sWren4, decWren4;
    logic [7:0] sAddr4, sWrdata4, sRd4, encRd4, decWrdata4;
    logic [4:0] encAddr4, decAddr4;

    logic       start32, fin32, kw32, busy32, sWren32, decWren32;
    logic [7:0] sAddr32, sWrdata32, sRd32, encRd32, decWrdata32;
    logic [4:0] encAddr32, decAddr32;

    logic fin, kw, busy;

    logic [7:0] s4 [256];
    logic [7:0] enc4 [32];
    logic [7:0] dec4 [32];
    logic [7:0] s32 [256];
    logic [7:0] enc32 [32];
    logic [7:0] dec32 [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign start4  = startDrv & ~sel;
    assign start32 = startDrv & sel;
    assign fin     = sel ? fin32  : fin4;
    assign kw      = sel ? kw32   : kw4;
    assign busy    = sel ? busy32 : busy4;

    rc4_prga_decrypt #(.MSG_LEN(4), .MSG_AW(5)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_DMB  (start4),
        .finish_DMB (fin4),
        .key_wrong  (kw4),
        .busy       (busy4),
        .s_addr     (sAddr4),
        .s_wrdata   (sWrdata4),
        .s_wren     (sWren4),
        .s_rddata   (sRd4),
        .enc_addr   (encAddr4),
        .enc_rddata (encRd4),
        .dec_addr   (decAddr4),
        .dec_wrdata (decWrdata4),
        .dec_wren   (decWren4)
    );

    rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(5)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_DMB  (start32),
        .finish_DMB (fin32),
        .key_wrong  (kw32),
        .busy       (busy32),
        .s_addr     (sAddr32),
        .s_wrdata   (sWrdata32),
        .s_wren     (sWren32),
        .s_rddata   (sRd32),
        .enc_addr   (encAddr32),
        .enc_rddata (encRd32),
        .dec_addr   (decAddr32),
        .dec_wrdata (decWrdata32),
        .dec_wren   (decWren32)
    );

    // Synchronous-read memories for the 4-byte instance.
    always @(posedge clk) begin
        sRd4   <= s4[sAddr4];
        encRd4 <= enc4[encAddr4];
        if (sWren4) s4[sAddr4] = sWrdata4;
        if (decWren4) dec4[decAddr4] = decWrdata4;
    end

    // Synchronous-read memories for the 32-byte instance.
    always @(posedge clk) begin
        sRd32   <= s32[sAddr32];
        encRd32 <= enc32[encAddr32];
        if (sWren32) s32[sAddr32] = sWrdata32;
        if (decWren32) dec32[decAddr32] = decWrdata32;
    end

    task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
        end
    endtask

    task initS4();
        for (int x = 0; x < 256; x++) s4[x] = 8'(x);
    endtask

    task clearDec4();
        for (int x = 0; x < 32; x++) dec4[x] = 8'hEE;
    endtask

    task loadEnc4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        for (int x = 0; x < 32; x++) enc4[x] = 8'h00;
        enc4[0] = b0;
        enc4[1] = b1;
        enc4[2] = b2;
        enc4[3] = b3;
    endtask

    // Pulse start, then watch the selected instance for a bounded number of
    // cycles. Cycle c is the cycle after the c-th rising edge past the pulse.
    task applyStimulus(input bit useSel, input int maxCycles, input bit extra,
                       output int finCycle, output int finCount,
                       output int kwCycle, output int kwCount, output bit busyAfter);
        sel       = useSel;
        finCycle  = -1;
        finCount  = 0;
        kwCycle   = -1;
        kwCount   = 0;
        busyAfter = 1'b0;
        @(negedge clk);
        startDrv = 1'b1;
        for (int c = 1; c <= maxCycles; c++) begin
            @(negedge clk);
            startDrv = 1'b0;
            if (extra && (c == 3 || c == 17 || c == 29)) startDrv = 1'b1;
            if (busy && ((finCycle >= 0) || (kwCycle >= 0))) busyAfter = 1'b1;
            if (fin) begin
                finCount++;
                if (finCycle < 0) finCycle = c;
                if (extra) startDrv = 1'b1;
            end
            if (kw) begin
                kwCount++;
                if (kwCycle < 0) kwCycle = c;
            end
        end
        startDrv = 1'b0;
    endtask

    int  finCycle, finCount, kwCycle, kwCount;
    bit  busyAfter;
    logic [7:0] badBytes [3];
    logic [7:0] model [256];
    logic [7:0] key [3];
    logic [7:0] mi, mj, mt, ks;
    string pt;
    int guard, mism, busySeen;

    initial begin
        startDrv = 1'b0;
        sel      = 1'b0;
        rst_n    = 1'b1;
        initS4();
        clearDec4();
        loadEnc4(8'h63, 8'h67, 8'h27, 8'h77);
        for (int x = 0; x < 256; x++) s32[x] = 8'(x);
        for (int x = 0; x < 32; x++) begin
            enc32[x] = 8'h00;
            dec32[x] = 8'hEE;
        end

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rstBusy", busy4, 1'b0);
        checkOutput("rstOutputs", {fin4, kw4, sWren4, decWren4, sAddr4, sWrdata4,
                                   encAddr4, decAddr4, decWrdata4}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Main pass: identity S, "ab z"
        applyStimulus(1'b0, 60, 1'b0, finCycle, finCount, kwCycle, kwCount, busyAfter);
        checkOutput("passFinCycle", finCycle, 41);
        checkOutput("passFinCount", finCount, 1);
        checkOutput("passKwCount", kwCount, 0);
        checkOutput("passDec", {dec4[0], dec4[1], dec4[2], dec4[3]}, 32'h6162207A);
        checkOutput("passS2359", {s4[2], s4[3], s4[5], s4[9]}, 32'h03050204);
        checkOutput("passS4", s4[4], 8'h09);

        // Invalid third byte
        initS4();
        clearDec4();
        loadEnc4(8'h63, 8'h67, 8'h26, 8'h77);
        applyStimulus(1'b0, 60, 1'b0, finCycle, finCount, kwCycle, kwCount, busyAfter);
        checkOutput("failKwCycle", kwCycle, 31);
        checkOutput("failKwCount", kwCount, 1);
        checkOutput("failFinCount", finCount, 0);
        checkOutput("failDec", {dec4[0], dec4[1], dec4[2], dec4[3]}, 32'h6162EEEE);

        // Just-outside boundary characters in the first byte (keystream 02)
        badBytes[0] = 8'h60;
        badBytes[1] = 8'h7B;
        badBytes[2] = 8'h1F;
        for (int b = 0; b < 3; b++) begin
            initS4();
            clearDec4();
            loadEnc4(badBytes[b] ^ 8'h02, 8'h67, 8'h27, 8'h77);
            applyStimulus(1'b0, 30, 1'b0, finCycle, finCount, kwCycle, kwCount, busyAfter);
            checkOutput($sformatf("edgeKw%0h", badBytes[b]), kwCycle, 11);
            checkOutput($sformatf("edgeFin%0h", badBytes[b]), finCount, 0);
            checkOutput($sformatf("edgeDec%0h", badBytes[b]), dec4[0], 8'hEE);
        end

        // Extra starts mid-pass and start held in the DONE cycle
        initS4();
        clearDec4();
        loadEnc4(8'h63, 8'h67, 8'h27, 8'h77);
        applyStimulus(1'b0, 60, 1'b1, finCycle, finCount, kwCycle, kwCount, busyAfter);
        checkOutput("extraFinCycle", finCycle, 41);
        checkOutput("extraFinCount", finCount, 1);
        checkOutput("extraBusyAfter", busyAfter, 1'b0);
        checkOutput("extraDec", {dec4[0], dec4[1], dec4[2], dec4[3]}, 32'h6162207A);

        // Asynchronous reset in the middle of a byte
        initS4();
        clearDec4();
        sel = 1'b0;
        @(negedge clk);
        startDrv = 1'b1;
        @(negedge clk);
        startDrv = 1'b0;
        guard = 0;
        while (!sWren4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reachWrI", sWren4, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstBusy", busy4, 1'b0);
        checkOutput("midRstOutputs", {fin4, kw4, sWren4, decWren4, sAddr4, sWrdata4,
                                      encAddr4, decAddr4, decWrdata4}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        busySeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy4) busySeen++;
        end
        checkOutput("postRstIdle", busySeen, 0);
        initS4();
        clearDec4();
        applyStimulus(1'b0, 60, 1'b0, finCycle, finCount, kwCycle, kwCount, busyAfter);
        checkOutput("rerunFinCycle", finCycle, 41);
        checkOutput("rerunDec", {dec4[0], dec4[1], dec4[2], dec4[3]}, 32'h6162207A);

        // 32-byte message, S from the key-schedule for key 00 00 01
        key[0] = 8'h00;
        key[1] = 8'h00;
        key[2] = 8'h01;
        for (int x = 0; x < 256; x++) model[x] = 8'(x);
        mj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            mj = mj + model[x] + key[x % 3];
            mt = model[x];
            model[x] = model[mj];
            model[mj] = mt;
        end
        for (int x = 0; x < 256; x++) s32[x] = model[x];
        pt = "the quick brown fox jumps over a";
        mi = 8'd0;
        mj = 8'd0;
        for (int k = 0; k < 32; k++) begin
            mi = mi + 8'd1;
            mj = mj + model[mi];
            mt = model[mi];
            model[mi] = model[mj];
            model[mj] = mt;
            ks = model[8'(model[mi] + model[mj])];
            enc32[k] = pt[k] ^ ks;
        end
        applyStimulus(1'b1, 340, 1'b0, finCycle, finCount, kwCycle, kwCount, busyAfter);
        checkOutput("long FinCycle", finCycle, 321);
        checkOutput("longKwCount", kwCount, 0);
        mism = 0;
        for (int k = 0; k < 32; k++) if (dec32[k] !== pt[k]) mism++;
        checkOutput("longDecMism", mism, 0);
        mism = 0;
        for (int x = 0; x < 256; x++) if (s32[x] !== model[x]) mism++;
        checkOutput("longSMism", mism, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- RC4 pseudo-random generation and decrypt stage.
- Runs after the S-array shuffle. It is launched by the core controller via start_DMB and returns finish_DMB or key_wrong.
- Reads the shuffled S RAM and swaps entries in place. Reads the encrypted message ROM, XORs it with the keystream, writes plaintext to the decrypted RAM, and validates every character.
- An invalid character aborts the pass so the controller can advance to the next key.

Parameters:
MSG_LEN, 32, number of message bytes to decrypt (1..2**MSG_AW)
MSG_AW, 5, message ROM/RAM address width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_DMB  input  1  single-cycle start pulse from controller; ignored unless IDLE
finish_DMB  output  1  single-cycle pulse: all MSG_LEN bytes decrypted and valid
key_wrong  output  1  single-cycle pulse: invalid plaintext byte found, pass aborted
busy  output  1  high in every state except IDLE
s_addr  output  8  S RAM address
s_wrdata  output  8  S RAM write data
s_wren  output  1  S RAM write enable
s_rddata  input  8  S RAM read data; valid in the cycle after s_addr is driven
enc_addr  output  MSG_AW  encrypted ROM address
enc_rddata  input  8  encrypted ROM data; valid in the cycle after enc_addr is driven
dec_addr  output  MSG_AW  decrypted RAM address
dec_wrdata  output  8  decrypted RAM write data
dec_wren  output  1  decrypted RAM write enable

Behaviour:
- Reset is asynchronous with rst_n low:
  - state=IDLE; internal registers i, j, k, si, sj, f and e all cleared to 0.
  - All outputs 0.
  - Reset mid-pass abandons the pass; S and dec RAM contents are left as partially written.
- Outputs are Moore, decoded from state and registers. Addresses and data read 0 in states that do not use them. Enables are high only where listed.
- Arithmetic: i, j and all S indices are 8-bit and wrap mod 256. k is MSG_AW bits.
- Per-byte state sequence (10 cycles/byte):
  - IDLE: on start_DMB, i<=0, j<=0, k<=0, go INC_I.
  - INC_I: i<=i+1.
  - RD_SI: s_addr=i.
  - WAIT_SI: si<=s_rddata; j<=j+s_rddata.
  - RD_SJ: s_addr=j (updated j).
  - WAIT_SJ: sj<=s_rddata.
  - WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1. When i==j both writes store the same value, which is correct.
  - RD_F: s_addr=si+sj, enc_addr=k.
  - WAIT_F: f<=s_rddata; e<=enc_rddata.
  - CHECK: d=f^e. d is valid iff 0x61<=d<=0x7A or d==0x20.
    - Valid: dec_addr=k, dec_wrdata=d, dec_wren=1. If k==MSG_LEN-1 go DONE, else k<=k+1 and go INC_I.
    - Invalid: no dec write, go FAIL.
  - DONE: finish_DMB=1 for one cycle, then IDLE.
  - FAIL: key_wrong=1 for one cycle, then IDLE.
- finish_DMB and key_wrong are mutually exclusive and never both pulse in one pass.
- start_DMB while busy=1 is ignored. start_DMB held high in the DONE or FAIL cycle is also ignored. A new pass starts only on a start_DMB seen in IDLE.
- Latency:
  - Successful pass: start accepted at edge 0; finish_DMB high exactly 10*MSG_LEN+1 cycles later.
  - Failure at byte n (0-based): key_wrong high 10*(n+1)+1 cycles after start.
- A new pass does not reinitialise S; the controller reruns fill and shuffle first.

Test Plan:
- MSG_LEN=4, S preloaded identity (S[x]=x), enc = 63 67 27 77, pulse start -> keystream 02 05 07 0D:
  - dec RAM = 61 62 20 7A ("ab z").
  - finish_DMB single pulse 41 cycles after start; key_wrong never high.
  - S[2]=3, S[3]=5, S[5]=2, S[4]=9, S[9]=4.
- Same setup with enc[2]=0x26 -> d=0x21 invalid:
  - dec[0..1] written, dec[2..3] untouched.
  - key_wrong pulse 31 cycles after start; finish_DMB never high.
- Boundary characters: plaintext bytes 0x60, 0x7B, 0x1F each cause key_wrong. Bytes 0x61, 0x7A, 0x20 pass.
- Extra start_DMB pulses during a pass, and start_DMB held in the DONE cycle -> no restart; pass timing and results unchanged; exactly one finish_DMB.
- Assert rst_n low mid-byte (e.g. in WR_I) -> outputs 0 immediately with no clock edge. After release, busy=0 until the next start_DMB; the next pass runs normally from i=j=k=0.
- MSG_LEN=32, S from a known KSA vector (key 0x000001) vs. software model -> all 32 dec bytes match; finish_DMB at cycle 321.
